// File: rtl/mux_nto1_stream.sv
// N-to-1 valid/ready stream mux with one registered output beat, explicit-select or round-robin grant.
// Optional MUX_NTO1_STREAM_COUNT_EN adds a 16-bit xfer_count of output transfers.
module mux_nto1_stream #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef MUX_NTO1_STREAM_COUNT_EN
  output logic [15:0]               xfer_count,
`endif
  output logic [SEL_W-1:0]          out_chan
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_chan;
  logic [SEL_W-1:0] r_ptr;

  logic             w_space;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_load;

  assign w_space = !r_out_valid || out_ready;

  // Downward scan so the channel closest to r_ptr is assigned last and wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (MODE == 0) begin
      if (32'(sel) < CHANNELS) begin
        w_gnt_vld = 1'b1;
        w_gnt     = sel;
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        int idx;
        idx = int'(r_ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (in_valid[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (32'(w_gnt) == i) begin
        in_ready[i] = w_gnt_vld && w_space && !rst;
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_load = |(in_ready & in_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_data  <= w_gnt_data;
      r_out_chan  <= w_gnt;
      r_out_valid <= 1'b1;
      if (MODE == 1) r_ptr <= (32'(w_gnt) == CHANNELS - 1) ? '0 : w_gnt + SEL_W'(1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MUX_NTO1_STREAM_COUNT_EN
  logic [15:0] r_xfer_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_xfer_count <= '0;
    else if (r_out_valid && out_ready) r_xfer_count <= r_xfer_count + 16'd1;
  end
  assign xfer_count = r_xfer_count;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench: select mode (4 and 3 channels) and round-robin mode instances.
module tb_mux_nto1_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Select-mode, 4 channels
  logic [15:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic [1:0]  a_sel, a_chan;
  logic [3:0]  a_odata;
  logic        a_ovalid, a_ordy;
  // Select-mode, 3 channels
  logic [11:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic [1:0]  b_sel, b_chan;
  logic [3:0]  b_odata;
  logic        b_ovalid, b_ordy;
  // Round-robin, 4 channels
  logic [15:0] c_data;
  logic [3:0]  c_valid, c_ready;
  logic [1:0]  c_sel, c_chan;
  logic [3:0]  c_odata;
  logic        c_ovalid, c_ordy;
`ifdef MUX_NTO1_STREAM_COUNT_EN
  logic [15:0] a_cnt, b_cnt, c_cnt;
`endif

  mux_nto1_stream #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_ordy),
`ifdef MUX_NTO1_STREAM_COUNT_EN
    .xfer_count(a_cnt),
`endif
    .out_chan(a_chan));

  mux_nto1_stream #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .MODE(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_ordy),
`ifdef MUX_NTO1_STREAM_COUNT_EN
    .xfer_count(b_cnt),
`endif
    .out_chan(b_chan));

  mux_nto1_stream #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .MODE(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_ordy),
`ifdef MUX_NTO1_STREAM_COUNT_EN
    .xfer_count(c_cnt),
`endif
    .out_chan(c_chan));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_data = {4'd4, 4'd3, 4'd2, 4'd1}; a_valid = 4'b1111; a_sel = 2'd1; a_ordy = 1'b0;
    #1;
    vecs++; if (a_ready !== 4'b0000) begin errs++; $display("FAIL reset_rdy got=%b exp=0000", a_ready); end
    vecs++; if ({a_ovalid, a_odata, a_chan} !== 7'd0) begin errs++; $display("FAIL reset_out got=%b/%h/%0d exp=0/0/0", a_ovalid, a_odata, a_chan); end
    step();
    rst = 1'b0;
    step();
    vecs++; if ({a_ovalid, a_odata, a_chan} !== {1'b1, 4'd2, 2'd1}) begin errs++; $display("FAIL load_before_rst got=%b/%h/%0d exp=1/2/1", a_ovalid, a_odata, a_chan); end
    #2 rst = 1'b1;
    #1;
    vecs++; if ({a_ovalid, a_odata, a_chan} !== 7'd0) begin errs++; $display("FAIL async_rst got=%b/%h/%0d exp=0/0/0", a_ovalid, a_odata, a_chan); end
    vecs++; if (a_ready !== 4'b0000) begin errs++; $display("FAIL rst_rdy got=%b exp=0000", a_ready); end
    step();
    vecs++; if (a_ready !== 4'b0000 || a_ovalid !== 1'b0) begin errs++; $display("FAIL rst_hold got=%b/%b exp=0000/0", a_ready, a_ovalid); end
    rst = 1'b0;
    a_valid = 4'b0000;
  endtask

  task automatic test_select_sweep();
    a_valid = 4'b1111; a_ordy = 1'b1; a_sel = 2'd2;
    #1;
    vecs++; if (a_ready !== 4'b0100) begin errs++; $display("FAIL sweep_rdy2 got=%b exp=0100", a_ready); end
    step();
    a_sel = 2'd0;
    #1;
    vecs++; if ({a_ovalid, a_odata, a_chan} !== {1'b1, 4'd3, 2'd2}) begin errs++; $display("FAIL sweep_out2 got=%b/%h/%0d exp=1/3/2", a_ovalid, a_odata, a_chan); end
    vecs++; if (a_ready !== 4'b0001) begin errs++; $display("FAIL sweep_rdy0 got=%b exp=0001", a_ready); end
    step();
    a_valid = 4'b0000;
    vecs++; if ({a_ovalid, a_odata, a_chan} !== {1'b1, 4'd1, 2'd0}) begin errs++; $display("FAIL sweep_out0 got=%b/%h/%0d exp=1/1/0", a_ovalid, a_odata, a_chan); end
    step();
    vecs++; if ({a_ovalid, a_odata, a_chan} !== {1'b0, 4'd1, 2'd0}) begin errs++; $display("FAIL drain got=%b/%h/%0d exp=0/1/0", a_ovalid, a_odata, a_chan); end
  endtask

  task automatic test_backpressure();
    a_data = {4'd4, 4'd3, 4'd9, 4'd1}; a_valid = 4'b1111; a_sel = 2'd1; a_ordy = 1'b0;
    step();
    a_sel = 2'd3;
    #1;
    vecs++; if (a_ready !== 4'b0000) begin errs++; $display("FAIL bp_rdy got=%b exp=0000", a_ready); end
    vecs++; if ({a_ovalid, a_odata, a_chan} !== {1'b1, 4'd9, 2'd1}) begin errs++; $display("FAIL bp_load got=%b/%h/%0d exp=1/9/1", a_ovalid, a_odata, a_chan); end
    step();
    step();
    vecs++; if ({a_ovalid, a_odata, a_chan} !== {1'b1, 4'd9, 2'd1}) begin errs++; $display("FAIL bp_hold got=%b/%h/%0d exp=1/9/1", a_ovalid, a_odata, a_chan); end
    a_ordy = 1'b1;
    #1;
    vecs++; if (a_ready !== 4'b1000) begin errs++; $display("FAIL bp_release got=%b exp=1000", a_ready); end
    step();
    a_valid = 4'b0000;
    vecs++; if ({a_ovalid, a_odata, a_chan} !== {1'b1, 4'd4, 2'd3}) begin errs++; $display("FAIL bp_next got=%b/%h/%0d exp=1/4/3", a_ovalid, a_odata, a_chan); end
    step();
  endtask

  task automatic test_out_of_range();
    b_data = {4'hC, 4'hB, 4'hA}; b_valid = 3'b111; b_sel = 2'd3; b_ordy = 1'b1;
    #1;
    vecs++; if (b_ready !== 3'b000) begin errs++; $display("FAIL oor_rdy got=%b exp=000", b_ready); end
    step();
    step();
    vecs++; if (b_ovalid !== 1'b0) begin errs++; $display("FAIL oor_valid got=%b exp=0", b_ovalid); end
    b_sel = 2'd2;
    #1;
    vecs++; if (b_ready !== 3'b100) begin errs++; $display("FAIL oor_sel2_rdy got=%b exp=100", b_ready); end
    step();
    b_valid = 3'b000;
    vecs++; if ({b_ovalid, b_odata, b_chan} !== {1'b1, 4'hC, 2'd2}) begin errs++; $display("FAIL oor_sel2_out got=%b/%h/%0d exp=1/c/2", b_ovalid, b_odata, b_chan); end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_chan [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_dat  [5] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd5};
    c_data = {4'd8, 4'd7, 4'd6, 4'd5}; c_valid = 4'b1111; c_ordy = 1'b1; c_sel = 2'd3;
    #1;
    vecs++; if (c_ready !== 4'b0001) begin errs++; $display("FAIL rr_first_rdy got=%b exp=0001", c_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      vecs++;
      if ({c_ovalid, c_odata, c_chan} !== {1'b1, exp_dat[k], exp_chan[k]}) begin
        errs++; $display("FAIL rr_seq%0d got=%b/%h/%0d exp=1/%h/%0d", k, c_ovalid, c_odata, c_chan, exp_dat[k], exp_chan[k]);
      end
    end
    c_valid = 4'b0100;
    #1;
    vecs++; if (c_ready !== 4'b0100) begin errs++; $display("FAIL rr_only2_rdy got=%b exp=0100", c_ready); end
    step();
    vecs++; if ({c_ovalid, c_odata, c_chan} !== {1'b1, 4'd7, 2'd2}) begin errs++; $display("FAIL rr_only2_out got=%b/%h/%0d exp=1/7/2", c_ovalid, c_odata, c_chan); end
    c_valid = 4'b1111;
    #1;
    vecs++; if (c_ready !== 4'b1000) begin errs++; $display("FAIL rr_ptr3 got=%b exp=1000", c_ready); end
    c_valid = 4'b0000;
    step();
    step();
    vecs++; if (c_ovalid !== 1'b0) begin errs++; $display("FAIL rr_drain got=%b exp=0", c_ovalid); end
    c_valid = 4'b0011;
    #1;
    vecs++; if (c_ready !== 4'b0001) begin errs++; $display("FAIL rr_idle_wrap got=%b exp=0001", c_ready); end
    c_valid = 4'b0000;
    step();
  endtask

`ifdef MUX_NTO1_STREAM_COUNT_EN
  task automatic test_counter();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (a_cnt !== 16'd0) begin errs++; $display("FAIL cnt_reset got=%0d exp=0", a_cnt); end
    a_valid = 4'b1111; a_sel = 2'd0; a_ordy = 1'b1;
    repeat (65538) step();
    vecs++; if (a_cnt !== 16'd1) begin errs++; $display("FAIL cnt_wrap got=%0d exp=1", a_cnt); end
    a_valid = 4'b0000;
  endtask
`endif

  initial begin
    a_data = '0; a_valid = '0; a_sel = '0; a_ordy = 1'b0;
    b_data = '0; b_valid = '0; b_sel = '0; b_ordy = 1'b0;
    c_data = '0; c_valid = '0; c_sel = '0; c_ordy = 1'b0;
    test_reset();
    test_select_sweep();
    test_backpressure();
    test_out_of_range();
    test_round_robin();
`ifdef MUX_NTO1_STREAM_COUNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mux_nto1_stream.md
Name: mux_nto1_stream

Overview:
Parametrised N-to-1 stream multiplexer with a registered output stage and valid/ready handshaking on every channel. It is the successor to the combinational 2:1 selector. It generalises width and channel count, and adds a selectable arbitration mode: explicit select, or round-robin. It sits between several producer streams and a single consumer, for example when merging channel data into one datapath.

Parameters:
- WIDTH, 4, data bits per channel.
- CHANNELS, 4, number of input channels (>=2, need not be a power of 2).
- SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= CHANNELS.
- MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed input data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready.
- sel  input  SEL_W  channel select; used when MODE=0.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output beat held.
- out_ready  input  1  consumer accepts the beat.
- out_chan  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer=0.
  - A beat held in the output register is discarded, and no in_ready is asserted during reset.
- Handshake:
  - A transfer occurs on a channel when valid&&ready are both high at a rising clk edge.
  - in_valid/in_data must hold until the transfer occurs.
- Output register is one entry. It can load when space = !out_valid || out_ready (load and drain may occur in the same cycle).
- Grant g (combinational, one channel or none):
  - MODE=0: g = sel if sel < CHANNELS, otherwise none. in_valid[sel] does not affect the grant itself.
  - MODE=1: g = the first i with in_valid[i]=1, scanning ptr, ptr+1, ... wrapping at CHANNELS-1 -> 0. No valid channel -> none.
- in_ready[i] = (i==g) && space. All other bits are 0, so only one channel is ever ready.
- Load on a transfer from g:
  - out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - MODE=1 only: ptr <= (g==CHANNELS-1) ? 0 : g+1.
- Drain without load: out_ready && out_valid && no input transfer -> out_valid <= 0. out_data and out_chan keep their last values.
- Held beat with out_ready=0: out_data and out_chan are stable. A change of sel, or new in_valid activity, does not alter them.
- Latency: input transfer at edge N -> out_valid=1 with that data after edge N.
- Throughput: one beat per cycle when out_ready is held at 1.
- Ptr only changes on a transfer; idle cycles leave it unchanged.
- sel may change on any cycle; it only affects which channel is ready in that cycle.

Optional Feature:
- Macro MUX_NTO1_STREAM_COUNT_EN.
- Defined:
  - Adds output port xfer_count (output, 16 bits), the count of output transfers (out_valid&&out_ready).
  - Reset value 0; increments by 1 per output transfer; wraps 65535 -> 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: assert rst mid-beat with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately (asynchronously), in_ready=0000 while rst=1.
- MODE=0 select sweep: WIDTH=4, CHANNELS=4, all valid, data ch0..3 = 1,2,3,4, out_ready=1, sel=2 then 0 -> in_ready 0100 then 0001; outputs one cycle later: out_data=3 with out_chan=2, then out_data=1 with out_chan=0.
- Backpressure: out_ready=0 after one load of value 9 from sel=1, then change sel to 3 -> out_data stays 9, out_chan stays 1, in_ready=0000 until out_ready=1; the next beat then comes from ch3.
- Out-of-range select: CHANNELS=3, sel=3 with all valid -> in_ready=000, out_valid stays 0.
- MODE=1 fairness: all four valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0. Then only ch2 valid and ptr=1 -> grant 2, and ptr becomes 3.
- Counter (macro defined): 65537 back-to-back output transfers from reset -> xfer_count=1 (wrapped); with the macro undefined, the build has no xfer_count port.
